matrix_ascii_printer: RTL and testbench

- Sequencer that walks a row-major byte matrix in a synchronous RAM, one element at a time.
- Drives the shared 8-bit binary-to-3-digit-ASCII converter for each element.
- Streams the resulting characters, with separators and line endings, to the UART transmit byte interface.
- Sits between matrix storage, the converter and the UART TX in the output path.

---
 rtl/matrix_ascii_printer.sv | 179 +++++++++++++++++
 tb/tb_matrix_ascii_printer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_ascii_printer.sv
// Walks a row-major byte matrix, converts each element via the shared bin->ASCII unit and streams "ddd" fields with SP/CRLF to UART TX.
// Per element: READ + RD_WAIT + CVT_REQ + converter latency + 4/5 TX beats; TX holds tx_data stable until tx_ready, converter waits on cvt_busy.
module matrix_ascii_printer #(
  parameter int                ADDR_W         = 5,
  parameter int                DIM_W          = 3,
  parameter logic [ADDR_W-1:0] BASE_ADDR      = '0,
  parameter bit                SUPPRESS_ZEROS = 1'b1
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              start,
  input  logic              abort,
  input  logic [DIM_W-1:0]  rows,
  input  logic [DIM_W-1:0]  cols,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              cvt_start,
  output logic [7:0]        cvt_bin,
  input  logic [23:0]       cvt_ascii,
  input  logic              cvt_done,
  input  logic              cvt_busy,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic              tx_ready
);

  typedef enum logic [3:0] {
    IDLE, READ, RD_WAIT, CVT_REQ, CVT_WAIT,
    SEND_H, SEND_T, SEND_O, SEND_SP, SEND_CR, SEND_LF, FINISH
  } state_t;

  localparam logic [7:0] CH_SP   = 8'h20;
  localparam logic [7:0] CH_ZERO = 8'h30;
  localparam logic [7:0] CH_CR   = 8'h0D;
  localparam logic [7:0] CH_LF   = 8'h0A;

  state_t            state, nextState;
  logic [ADDR_W-1:0] addr;
  logic [DIM_W-1:0]  rowCnt, colCnt, rowsQ, colsQ;
  logic [7:0]        cvtBinQ;
  logic [7:0]        digH, digT, digO;
  logic [7:0]        txChar;
  logic              lastCol, lastRow;
  logic              hZero, tZero;

  assign lastCol = (colCnt == colsQ - DIM_W'(1));
  assign lastRow = (rowCnt == rowsQ - DIM_W'(1));
  assign hZero   = (cvt_ascii[23:16] == CH_ZERO);
  assign tZero   = (cvt_ascii[15:8] == CH_ZERO);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    rd_en     = 1'b0;
    cvt_start = 1'b0;
    tx_valid  = 1'b0;
    txChar    = 8'h00;
    unique case (state)
      IDLE: begin
        if (start) begin
          nextState = (rows == '0 || cols == '0) ? FINISH : READ;
        end
      end
      READ: begin
        rd_en     = 1'b1;
        nextState = RD_WAIT;
      end
      RD_WAIT: nextState = CVT_REQ;
      CVT_REQ: begin
        if (!cvt_busy) begin
          cvt_start = 1'b1;
          nextState = CVT_WAIT;
        end
      end
      CVT_WAIT: begin
        if (cvt_done) nextState = SEND_H;
      end
      SEND_H: begin
        tx_valid = 1'b1;
        txChar   = digH;
        if (tx_ready) nextState = SEND_T;
      end
      SEND_T: begin
        tx_valid = 1'b1;
        txChar   = digT;
        if (tx_ready) nextState = SEND_O;
      end
      SEND_O: begin
        tx_valid = 1'b1;
        txChar   = digO;
        if (tx_ready) nextState = lastCol ? SEND_CR : SEND_SP;
      end
      SEND_SP: begin
        tx_valid = 1'b1;
        txChar   = CH_SP;
        if (tx_ready) nextState = READ;
      end
      SEND_CR: begin
        tx_valid = 1'b1;
        txChar   = CH_CR;
        if (tx_ready) nextState = SEND_LF;
      end
      SEND_LF: begin
        tx_valid = 1'b1;
        txChar   = CH_LF;
        if (tx_ready) nextState = lastRow ? FINISH : READ;
      end
      FINISH: nextState = IDLE;
      default: nextState = IDLE;
    endcase
    if (abort) nextState = IDLE;
  end

  // Datapath updates are suppressed on abort so a stale start cannot relatch the operands.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      addr    <= '0;
      rowCnt  <= '0;
      colCnt  <= '0;
      rowsQ   <= '0;
      colsQ   <= '0;
      cvtBinQ <= '0;
      digH    <= '0;
      digT    <= '0;
      digO    <= '0;
    end else if (!abort) begin
      unique case (state)
        IDLE: begin
          if (start) begin
            rowsQ  <= rows;
            colsQ  <= cols;
            addr   <= BASE_ADDR;
            rowCnt <= '0;
            colCnt <= '0;
          end
        end
        RD_WAIT: cvtBinQ <= rd_data;
        CVT_WAIT: begin
          if (cvt_done) begin
            digH <= (SUPPRESS_ZEROS && hZero) ? CH_SP : cvt_ascii[23:16];
            digT <= (SUPPRESS_ZEROS && hZero && tZero) ? CH_SP : cvt_ascii[15:8];
            digO <= cvt_ascii[7:0];
          end
        end
        SEND_SP: begin
          if (tx_ready) begin
            colCnt <= colCnt + DIM_W'(1);
            addr   <= addr + ADDR_W'(1);
          end
        end
        SEND_LF: begin
          if (tx_ready) begin
            colCnt <= '0;
            rowCnt <= rowCnt + DIM_W'(1);
            addr   <= addr + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy    = (state != IDLE);
  assign done    = (state == FINISH);
  assign rd_addr = addr;
  assign cvt_bin = cvtBinQ;
  assign tx_data = txChar;

endmodule

// File: tb/tb_matrix_ascii_printer.sv
// Directed bench for matrix_ascii_printer with RAM and converter models and a character scoreboard.
module tb_matrix_ascii_printer;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [2:0]  rows = '0;
  logic [2:0]  cols = '0;
  logic        busy, done, rd_en, cvt_start, cvt_done, cvt_busy, tx_valid;
  logic [4:0]  rd_addr;
  logic [7:0]  rd_data = '0;
  logic [7:0]  cvt_bin, tx_data;
  logic [23:0] cvt_ascii = '0;
  logic        tx_ready = 1'b1;

  int errors = 0;
  int checks = 0;

  logic [7:0] mem [32];
  logic [7:0] sbQ [$];
  logic [4:0] rdAddrQ [$];
  int txCount = 0, cvtStartCount = 0, doneCount = 0, rdEnCount = 0;
  bit randReady = 0, stabOn = 0, holdBusy = 0;
  logic prevStall = 1'b0;
  logic [7:0] prevData = '0;

  int cvtCnt = 0;
  int cvtVal = 0;

  matrix_ascii_printer dut (
    .clk(clk), .rstN(rstN), .start(start), .abort(abort), .rows(rows), .cols(cols),
    .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .cvt_start(cvt_start), .cvt_bin(cvt_bin), .cvt_ascii(cvt_ascii), .cvt_done(cvt_done),
    .cvt_busy(cvt_busy), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: data one cycle after rd_en.
  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

  // Converter: 3-cycle latency, busy while converting, one-cycle done pulse.
  assign cvt_busy = (cvtCnt != 0) || holdBusy;
  always @(posedge clk) begin
    cvt_done <= 1'b0;
    if (cvtCnt != 0) begin
      cvtCnt <= cvtCnt - 1;
      if (cvtCnt == 1) begin
        cvt_done  <= 1'b1;
        cvt_ascii <= {8'(48 + cvtVal / 100), 8'(48 + (cvtVal / 10) % 10), 8'(48 + cvtVal % 10)};
      end
    end else if (cvt_start) begin
      cvtCnt <= 3;
      cvtVal <= int'(cvt_bin);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted character.
  always @(negedge clk) begin
    if (rstN) begin
      if (stabOn && prevStall) begin
        check("tx_hold_valid", {31'h0, tx_valid}, 32'h1);
        check("tx_hold_data", {24'h0, tx_data}, {24'h0, prevData});
      end
      prevStall = tx_valid && !tx_ready;
      prevData  = tx_data;
      if (rd_en) begin
        rdEnCount++;
        rdAddrQ.push_back(rd_addr);
      end
      if (cvt_start) cvtStartCount++;
      if (done) doneCount++;
      if (tx_valid && tx_ready) begin
        txCount++;
        if (sbQ.size() == 0) begin
          check("tx_extra_char", {24'h0, tx_data}, 32'hFFFF_FFFF);
        end else begin
          check("tx_char", {24'h0, tx_data}, {24'h0, sbQ.pop_front()});
        end
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #2;
    if (randReady) tx_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pulseStart(input logic [2:0] r, input logic [2:0] c);
    rows = r;
    cols = c;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic clearCounts();
    txCount = 0; cvtStartCount = 0; doneCount = 0; rdEnCount = 0;
    rdAddrQ.delete();
  endtask

  task automatic pushVal(input logic [7:0] v);
    int h, t, o;
    h = int'(v) / 100;
    t = (int'(v) / 10) % 10;
    o = int'(v) % 10;
    sbQ.push_back(h == 0 ? 8'h20 : 8'(48 + h));
    sbQ.push_back((h == 0 && t == 0) ? 8'h20 : 8'(48 + t));
    sbQ.push_back(8'(48 + o));
  endtask

  task automatic pushMatrix(input int r, input int c);
    for (int i = 0; i < r; i++) begin
      for (int j = 0; j < c; j++) begin
        pushVal(mem[(i * c + j) % 32]);
        if (j < c - 1) sbQ.push_back(8'h20);
        else begin
          sbQ.push_back(8'h0D);
          sbQ.push_back(8'h0A);
        end
      end
    end
  endtask

  task automatic waitDone(input string tag, input int budget, output int n);
    n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_done"}, {31'h0, done}, 32'h1);
    check({tag, "_sb_empty_at_done"}, sbQ.size(), 32'h0);
    check({tag, "_busy_in_finish"}, {31'h0, busy}, 32'h1);
    tick();
    check({tag, "_idle_after_done"}, {31'h0, busy}, 32'h0);
  endtask

  task automatic checkResetOutputs(input string tag);
    check({tag, "_busy"}, {31'h0, busy}, 32'h0);
    check({tag, "_done"}, {31'h0, done}, 32'h0);
    check({tag, "_rd_en"}, {31'h0, rd_en}, 32'h0);
    check({tag, "_rd_addr"}, {27'h0, rd_addr}, 32'h0);
    check({tag, "_cvt_start"}, {31'h0, cvt_start}, 32'h0);
    check({tag, "_cvt_bin"}, {24'h0, cvt_bin}, 32'h0);
    check({tag, "_tx_valid"}, {31'h0, tx_valid}, 32'h0);
    check({tag, "_tx_data"}, {24'h0, tx_data}, 32'h0);
  endtask

  initial begin
    int n;
    int stray;
    for (int i = 0; i < 32; i++) mem[i] = 8'(i * 3);

    #1;
    checkResetOutputs("reset");
    tick();
    rstN = 1'b1;
    tick();

    // 1x1 zero element
    mem[0] = 8'd0;
    clearCounts();
    pushMatrix(1, 1);
    pulseStart(3'd1, 3'd1);
    waitDone("one", 200, n);
    check("one_done_count", doneCount, 1);
    check("one_cvt_starts", cvtStartCount, 1);
    check("one_tx_count", txCount, 5);

    // 2x2 with mixed suppression
    mem[0] = 8'd255; mem[1] = 8'd7; mem[2] = 8'd45; mem[3] = 8'd105;
    clearCounts();
    pushMatrix(2, 2);
    pulseStart(3'd2, 3'd2);
    waitDone("two", 400, n);
    check("two_rd_count", rdAddrQ.size(), 4);
    for (int i = 0; i < 4 && i < rdAddrQ.size(); i++) check("two_rd_addr", {27'h0, rdAddrQ[i]}, i);
    check("two_tx_count", txCount, 18);
    check("two_done_count", doneCount, 1);

    // Same 2x2 with random backpressure
    clearCounts();
    pushMatrix(2, 2);
    randReady = 1; stabOn = 1;
    pulseStart(3'd2, 3'd2);
    waitDone("rand", 2000, n);
    randReady = 0; stabOn = 0;
    tick();
    tx_ready = 1'b1;
    check("rand_tx_count", txCount, 18);

    // Degenerate dimensions
    clearCounts();
    pulseStart(3'd0, 3'd3);
    waitDone("zero", 5, n);
    check("zero_latency_ok", {31'h0, n <= 2}, 32'h1);
    check("zero_rd_en", rdEnCount, 0);
    check("zero_cvt_start", cvtStartCount, 0);
    check("zero_tx", txCount, 0);

    // 3x3: ignored restart, then abort during third conversion
    mem[0] = 8'd12; mem[1] = 8'd0; mem[2] = 8'd200; mem[3] = 8'd9; mem[4] = 8'd99;
    mem[5] = 8'd100; mem[6] = 8'd250; mem[7] = 8'd1; mem[8] = 8'd77;
    clearCounts();
    pushVal(mem[0]); sbQ.push_back(8'h20);
    pushVal(mem[1]); sbQ.push_back(8'h20);
    pulseStart(3'd3, 3'd3);
    n = 0;
    while (txCount < 4 && n < 200) begin tick(); n++; end
    check("abort_reach_4th", {31'h0, txCount >= 4}, 32'h1);
    pulseStart(3'd1, 3'd1);
    n = 0;
    while (!(txCount == 8 && cvt_start) && n < 200) begin tick(); n++; end
    check("abort_reach_cvt", {31'h0, cvt_start}, 32'h1);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_tx_valid", {31'h0, tx_valid}, 32'h0);
    check("abort_busy", {31'h0, busy}, 32'h0);
    for (int i = 0; i < 6; i++) tick();
    check("abort_no_done", doneCount, 0);
    check("abort_tx_count", txCount, 8);
    check("abort_rd_count", rdEnCount, 3);
    check("abort_sb_empty", sbQ.size(), 0);
    check("abort_busy_stays_low", {31'h0, busy}, 32'h0);
    clearCounts();
    pushMatrix(3, 3);
    pulseStart(3'd3, 3'd3);
    waitDone("reprint", 1000, n);
    check("reprint_rd_count", rdAddrQ.size(), 9);
    if (rdAddrQ.size() == 9) begin
      check("reprint_first_addr", {27'h0, rdAddrQ[0]}, 0);
      check("reprint_last_addr", {27'h0, rdAddrQ[8]}, 8);
    end

    // Converter busy hold, then reset while presenting the tens digit
    mem[0] = 8'd123;
    clearCounts();
    pushMatrix(1, 1);
    holdBusy = 1; tx_ready = 1'b0;
    pulseStart(3'd1, 3'd1);
    n = 0;
    while (!rd_en && n < 20) begin tick(); n++; end
    check("hold_saw_rd_en", {31'h0, rd_en}, 32'h1);
    tick(); tick();
    stray = 0;
    for (int i = 0; i < 10; i++) begin
      if (cvt_start) stray++;
      tick();
    end
    check("hold_no_cvt_start", stray, 0);
    holdBusy = 0;
    #1;
    check("hold_cvt_start_on_release", {31'h0, cvt_start}, 32'h1);
    n = 0;
    while (!tx_valid && n < 20) begin tick(); n++; end
    check("hold_hundreds", {24'h0, tx_data}, 32'h31);
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    check("hold_tens_presented", {24'h0, tx_data}, 32'h32);
    rstN = 1'b0;
    #1;
    checkResetOutputs("midreset");
    sbQ.delete();
    tick();
    rstN = 1'b1;
    tx_ready = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
